dmem_access_unit: RTL

//  Memory-stage front end that sits directly upstream of the load formatter.

---
 rtl/dmem_access_unit.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/dmem_access_unit.sv
// Memory-stage load/store front end: runs one valid/ready data-memory access per
// pipeline op, stalls the pipeline while in flight, and hands load data to the formatter.
module dmem_access_unit #(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       store_data,
  output logic              stall,
  output logic              misaligned,
  output logic              bus_error,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [3:0]        mem_wstrb,
  output logic [31:0]       mem_wdata,
  input  logic              mem_rsp_valid,
  input  logic [31:0]       mem_rsp_data,
  output logic [31:0]       DMEM_word,
  output logic [1:0]        byte_offset,
  output logic [2:0]        load_funct3,
  output logic              load_valid
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t            state, state_d;
  logic [CNT_W-1:0]  cnt, cnt_d;
  logic [1:0]        cap_off, cap_off_d;
  logic [2:0]        cap_f3, cap_f3_d;

  logic              misaligned_d, bus_error_d, load_valid_d;
  logic              mem_req_valid_d, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [3:0]        mem_wstrb_d;
  logic [31:0]       mem_wdata_d;
  logic [31:0]       dmem_word_d;
  logic [1:0]        byte_offset_d;
  logic [2:0]        load_funct3_d;

  logic              op_present, op_legal, op_misaligned;
  logic [3:0]        st_wstrb;
  logic [31:0]       st_wdata;

  // A simultaneous read+write request is handled as a read
  assign op_present    = MemRead | MemWrite;
  assign op_legal      = MemRead ? (funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})
                                 : (funct3 inside {3'b000, 3'b001, 3'b010});
  assign op_misaligned = ((funct3[1:0] == 2'b01) && addr[0]) ||
                         ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));

  // Store byte lanes; reads carry no strobes or data
  always_comb begin
    st_wstrb = 4'b0000;
    st_wdata = 32'h0;
    if (!MemRead) begin
      case (funct3[1:0])
        2'b00: begin
          st_wstrb = 4'b0001 << addr[1:0];
          st_wdata = {4{store_data[7:0]}};
        end
        2'b01: begin
          st_wstrb = 4'b0011 << addr[1:0];
          st_wdata = {2{store_data[15:0]}};
        end
        2'b10: begin
          st_wstrb = 4'b1111;
          st_wdata = store_data;
        end
        default: ;
      endcase
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d         = state;
    cnt_d           = cnt;
    cap_off_d       = cap_off;
    cap_f3_d        = cap_f3;
    mem_req_valid_d = mem_req_valid;
    mem_addr_d      = mem_addr;
    mem_we_d        = mem_we;
    mem_wstrb_d     = mem_wstrb;
    mem_wdata_d     = mem_wdata;
    dmem_word_d     = DMEM_word;
    byte_offset_d   = byte_offset;
    load_funct3_d   = load_funct3;
    misaligned_d    = 1'b0;
    bus_error_d     = 1'b0;
    load_valid_d    = 1'b0;
    stall           = 1'b0;

    case (state)
      IDLE: begin
        if (op_present && op_legal) begin
          if (op_misaligned) begin
            misaligned_d = 1'b1;
          end else begin
            stall           = 1'b1;
            state_d         = REQ;
            mem_req_valid_d = 1'b1;
            mem_addr_d      = {addr[ADDR_W-1:2], 2'b00};
            mem_we_d        = ~MemRead;
            mem_wstrb_d     = st_wstrb;
            mem_wdata_d     = st_wdata;
            cap_off_d       = addr[1:0];
            cap_f3_d        = funct3;
          end
        end
      end
      REQ: begin
        stall = 1'b1;
        if (mem_req_ready) begin
          mem_req_valid_d = 1'b0;
          if (mem_we) begin
            state_d = DONE;
          end else begin
            state_d = WAIT;
            cnt_d   = '0;
          end
        end
      end
      WAIT: begin
        stall = 1'b1;
        cnt_d = cnt + CNT_W'(1);
        // A response arriving on the last allowed cycle still completes the load
        if (mem_rsp_valid) begin
          state_d       = DONE;
          dmem_word_d   = mem_rsp_data;
          byte_offset_d = cap_off;
          load_funct3_d = cap_f3;
          load_valid_d  = 1'b1;
        end else if (cnt == TIMEOUT_LAST) begin
          state_d     = IDLE;
          bus_error_d = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      cap_off       <= '0;
      cap_f3        <= '0;
      mem_req_valid <= 1'b0;
      mem_addr      <= '0;
      mem_we        <= 1'b0;
      mem_wstrb     <= '0;
      mem_wdata     <= '0;
      DMEM_word     <= '0;
      byte_offset   <= '0;
      load_funct3   <= '0;
      misaligned    <= 1'b0;
      bus_error     <= 1'b0;
      load_valid    <= 1'b0;
    end else begin
      state         <= state_d;
      cnt           <= cnt_d;
      cap_off       <= cap_off_d;
      cap_f3        <= cap_f3_d;
      mem_req_valid <= mem_req_valid_d;
      mem_addr      <= mem_addr_d;
      mem_we        <= mem_we_d;
      mem_wstrb     <= mem_wstrb_d;
      mem_wdata     <= mem_wdata_d;
      DMEM_word     <= dmem_word_d;
      byte_offset   <= byte_offset_d;
      load_funct3   <= load_funct3_d;
      misaligned    <= misaligned_d;
      bus_error     <= bus_error_d;
      load_valid    <= load_valid_d;
    end
  end

endmodule
